// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer.
// State encoding and parameter defaults live here so every user agrees.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_e;

  localparam int TIMEOUT_DEF = 15;
  localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating event counter used for the hazard performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stall, branch flush, memory wait
// with timeout halt, plus saturating performance counters.
import hazard_pkg::*;

module hazard_sequencer #(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [4:0]       X_rt,
  input  logic             X_MemRead,
  input  logic             M_branchTaken,
  input  logic             M_memReq,
  input  logic             M_memReady,
  output logic             PCwrite,
  output logic             IFIDwrite,
  output logic             IFIDflush,
  output logic             hazardIDEXenable,
  output logic             EXMEMflush,
  output logic             pipeHold,
  output logic             errTimeout,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount,
  output logic [CNT_W-1:0] waitCount
);

  localparam int TW = $clog2(TIMEOUT + 1);

  hz_state_e state_q;
  hz_state_e state_d;
  logic [TW-1:0] tmr_q;
  logic [TW-1:0] tmr_d;
  logic [TW-1:0] tmr_inc;

  logic mem_stall;
  logic load_use;
  logic tmo_hit;
  logic stall_inc;
  logic flush_inc;
  logic wait_inc;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;

  assign mem_stall = M_memReq && !M_memReady;
  assign load_use  = X_MemRead && (X_rt != 5'd0) &&
                     ((X_rt == D_rs) || (X_rt == D_rt));

  // Timer is zero in RUN, so the first frozen cycle counts as wait #1.
  assign tmr_inc = tmr_q + TW'(1);
  assign tmo_hit = (tmr_inc == TW'(TIMEOUT));

  always_comb begin
    PCwrite          = 1'b1;
    IFIDwrite        = 1'b1;
    IFIDflush        = 1'b0;
    hazardIDEXenable = 1'b0;
    EXMEMflush       = 1'b0;
    pipeHold         = 1'b0;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;
    wait_inc         = 1'b0;
    state_d          = state_q;
    tmr_d            = tmr_q;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          PCwrite   = 1'b0;
          IFIDwrite = 1'b0;
          pipeHold  = 1'b1;
          wait_inc  = 1'b1;
          tmr_d     = tmr_inc;
          state_d   = tmo_hit ? HALT : MEM_WAIT;
        end else if (M_branchTaken) begin
          IFIDflush        = 1'b1;
          hazardIDEXenable = 1'b1;
          EXMEMflush       = 1'b1;
          flush_inc        = 1'b1;
        end else if (load_use) begin
          PCwrite          = 1'b0;
          IFIDwrite        = 1'b0;
          hazardIDEXenable = 1'b1;
          stall_inc        = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!M_memReady) begin
          PCwrite   = 1'b0;
          IFIDwrite = 1'b0;
          pipeHold  = 1'b1;
          wait_inc  = 1'b1;
          tmr_d     = tmr_inc;
          state_d   = tmo_hit ? HALT : MEM_WAIT;
        end else begin
          tmr_d   = '0;
          state_d = RUN;
        end
      end
      HALT: begin
        PCwrite   = 1'b0;
        IFIDwrite = 1'b0;
        pipeHold  = 1'b1;
      end
      default: begin
        tmr_d   = '0;
        state_d = RUN;
      end
    endcase

    // Reset drives the pipeline into a fully flushed, non-advancing state.
    if (rst) begin
      PCwrite          = 1'b0;
      IFIDwrite        = 1'b0;
      IFIDflush        = 1'b1;
      hazardIDEXenable = 1'b1;
      EXMEMflush       = 1'b1;
      pipeHold         = 1'b0;
      stall_inc        = 1'b0;
      flush_inc        = 1'b0;
      wait_inc         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wait_inc),
    .count (wait_cnt)
  );

  assign errTimeout = (state_q == HALT) && !rst;
  assign stallCount = rst ? '0 : stall_cnt;
  assign flushCount = rst ? '0 : flush_cnt;
  assign waitCount  = rst ? '0 : wait_cnt;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed plus random bench for hazard_sequencer against a rule-level
// model of the stall/flush/wait behaviour (TIMEOUT=4, CNT_W=3).
module tb_hazard_sequencer;

  localparam int TO  = 4;
  localparam int CW  = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    D_rs, D_rt, X_rt;
  logic          X_MemRead, M_branchTaken, M_memReq, M_memReady;
  logic          PCwrite, IFIDwrite, IFIDflush, hazardIDEXenable;
  logic          EXMEMflush, pipeHold, errTimeout;
  logic [CW-1:0] stallCount, flushCount, waitCount;

  int n_chk  = 0;
  int n_fail = 0;

  // model: mode 0=running 1=waiting on memory 2=halted
  int m_mode = 0;
  int m_waits = 0;
  int m_sc = 0;
  int m_fc = 0;
  int m_wc = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .D_rs             (D_rs),
    .D_rt             (D_rt),
    .X_rt             (X_rt),
    .X_MemRead        (X_MemRead),
    .M_branchTaken    (M_branchTaken),
    .M_memReq         (M_memReq),
    .M_memReady       (M_memReady),
    .PCwrite          (PCwrite),
    .IFIDwrite        (IFIDwrite),
    .IFIDflush        (IFIDflush),
    .hazardIDEXenable (hazardIDEXenable),
    .EXMEMflush       (EXMEMflush),
    .pipeHold         (pipeHold),
    .errTimeout       (errTimeout),
    .stallCount       (stallCount),
    .flushCount       (flushCount),
    .waitCount        (waitCount)
  );

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] xrt, input logic xmr, input logic br,
                      input logic req, input logic rdy);
    logic [5:0] ec;
    logic [5:0] oc;
    int es, ef, ew, ee;
    bit lu;
    @(negedge clk);
    rst = r; D_rs = rs; D_rt = rt; X_rt = xrt;
    X_MemRead = xmr; M_branchTaken = br; M_memReq = req; M_memReady = rdy;
    #1;
    es = r ? 0 : m_sc;
    ef = r ? 0 : m_fc;
    ew = r ? 0 : m_wc;
    ee = (!r && m_mode == 2) ? 1 : 0;
    lu = xmr && (xrt != 0) && (xrt == rs || xrt == rt);
    // {PCwrite, IFIDwrite, IFIDflush, bubble, EXMEMflush, pipeHold}
    ec = 6'b110000;
    if (r) begin
      ec = 6'b001110;
      m_mode = 0; m_waits = 0; m_sc = 0; m_fc = 0; m_wc = 0;
    end else if (m_mode == 2) begin
      ec = 6'b000001;
    end else if (m_mode == 1 && rdy) begin
      m_mode = 0; m_waits = 0;
    end else if (req && !rdy) begin
      ec = 6'b000001;
      m_wc = sat(m_wc);
      m_waits++;
      m_mode = (m_waits >= TO) ? 2 : 1;
    end else if (m_mode == 0 && br) begin
      ec = 6'b111110;
      m_fc = sat(m_fc);
    end else if (m_mode == 0 && lu) begin
      ec = 6'b000100;
      m_sc = sat(m_sc);
    end else if (m_mode == 1) begin
      // waiting with no request still counts as an unfinished access
      ec = 6'b000001;
      m_wc = sat(m_wc);
      m_waits++;
      m_mode = (m_waits >= TO) ? 2 : 1;
    end
    oc = {PCwrite, IFIDwrite, IFIDflush, hazardIDEXenable, EXMEMflush, pipeHold};
    chk("ctrl", int'(oc), int'(ec));
    chk("errTimeout", int'(errTimeout), ee);
    chk("stallCount", int'(stallCount), es);
    chk("flushCount", int'(flushCount), ef);
    chk("waitCount", int'(waitCount), ew);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mem(input logic rdy);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, rdy);
  endtask

  initial begin
    rst = 1'b1; D_rs = '0; D_rt = '0; X_rt = '0;
    X_MemRead = 1'b0; M_branchTaken = 1'b0; M_memReq = 1'b0; M_memReady = 1'b0;
    #1;
    chk("rst_ctrl_pre_edge",
        int'({PCwrite, IFIDwrite, IFIDflush, hazardIDEXenable, EXMEMflush, pipeHold}),
        int'(6'b001110));
    chk("rst_err_pre_edge", int'(errTimeout), 0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // load-use, then the same with X_rt=0
    step(1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b0, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd2, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();

    // branch beats load-use
    step(1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();

    // three wait cycles then ready
    mem(1'b0); mem(1'b0); mem(1'b0); mem(1'b1);
    idle();

    // branch on the wait exit cycle is deferred
    mem(1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();

    // reset in the middle of a wait
    mem(1'b0); mem(1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    idle();

    // timeout into halt, sticky until reset
    for (int i = 0; i < 6; i++) mem(1'b0);
    mem(1'b1);
    idle();
    step(1'b0, 5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // nine load-use events saturate a 3-bit counter
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
    end

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
